imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Upstream of the CPU core: receives a byte stream from a UART receiver and writes 16-bit instruction words into the write port of instruction memory.
- Holds the CPU (pc, register, zf, memory) in reset until a complete, checksum-valid program image is loaded, then releases it.
- Supports reload on request without a system reset.

Parameters:
- ADDR_W, 8, instruction address width; matches the pc width.
- OP_W, 16, instruction word width; must equal 2 x 8.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 50000, maximum idle clk cycles between bytes inside a frame.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle.
- rx_data  input  8  received byte.
- load_req  input  1  one-cycle pulse; abort or restart loading and re-hold the CPU in reset.
- wr_en  output  1  imem write strobe, one cycle per word.
- wr_addr  output  ADDR_W  imem write address.
- wr_data  output  OP_W  imem write data.
- cpu_rst_n  output  1  active-low reset to the CPU core; high only in state DONE.
- busy  output  1  high while a frame is in progress (states LEN, HI, LO, CSUM).
- done  output  1  high in state DONE.
- err  output  1  high in state ERR.

Behaviour:
- Frame format: SYNC_BYTE, LEN, then LEN words sent high byte first, then CSUM.
  - LEN=0 means 256 words.
  - CSUM is the XOR of the LEN byte and every payload byte.
- Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, cpu_rst_n=0, busy=0, done=0, err=0. Word counter, checksum and timeout counter are all cleared.
- States and transitions:
  - IDLE: a byte equal to SYNC_BYTE -> LEN. Any other byte is ignored.
  - LEN: store LEN; checksum=byte; wr_addr=0 -> HI.
  - HI: latch the high byte; checksum^=byte -> LO.
  - LO: checksum^=byte. Next cycle: wr_en=1 for one cycle, wr_data={hi,lo}, at the current wr_addr. Then wr_addr increments.
    - If this was word LEN (counter tracked in ADDR_W+1 bits) -> CSUM.
    - Otherwise -> HI.
  - CSUM: byte == checksum -> DONE; mismatch -> ERR.
  - DONE: cpu_rst_n=1. Incoming bytes are ignored.
  - ERR: cpu_rst_n=0; err=1. A SYNC_BYTE arriving here starts a new frame (-> LEN, err clears).
- cpu_rst_n is registered: it goes high the cycle after entering DONE and goes low the cycle after leaving DONE.
- Timeout:
  - The counter is cleared on every rx_valid and whenever the state is IDLE, DONE or ERR.
  - It counts only in LEN, HI, LO and CSUM.
  - Reaching TIMEOUT -> ERR.
- load_req, from any state -> IDLE, with wr_en=0 and the counters cleared. It has priority over a simultaneous rx_valid.
- A write to imem is never issued after ERR or load_req. Words already written stay in imem, and the CPU remains in reset.
- wr_addr wraps to 0 after 255. This happens only for LEN=0 and has no effect, because the frame ends there.
- Assertion of rst_n mid-frame returns to IDLE immediately, with all outputs at their reset values.

Decomposition:
- Shared package:
  - state enum {IDLE, LEN, HI, LO, CSUM, DONE, ERR}
  - SYNC_BYTE default
  - ADDR_W and OP_W constants, shared with pc and imem.
- Sub-module: loader_timeout, a TIMEOUT-bounded counter with clear and enable inputs and an expired output.
- The FSM, checksum and address logic stay in imem_loader.
- imem gains a write port (we, waddr, wdata) driven by this block.

Test Plan:
- Frame A5 02 12 34 56 78 CSUM (02^12^34^56^78=0A) -> wr_en pulses twice: addr0=16'h1234, addr1=16'h5678. Then done=1 and cpu_rst_n=1.
- Same frame with CSUM=0B -> err=1, cpu_rst_n stays 0, done=0.
- LEN=00 with 512 payload bytes and a correct CSUM -> 256 writes with addresses 0..255, then done=1.
- Stall TIMEOUT cycles after the HI byte -> err=1, no further wr_en. Then a fresh A5 frame loads correctly.
- load_req in DONE -> cpu_rst_n=0 the next cycle, state=IDLE. load_req coincident with rx_valid=A5 -> remains IDLE.
- Bytes 00 FF before A5 are ignored. rst_n low between the two data bytes of a word -> no write, all outputs reset.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants, state encoding and helpers for the instruction-memory loader.
// ADDR_W and OP_W are also used by the pc and the imem.
package imem_loader_pkg;

   localparam int unsigned ADDR_W      = 8;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned OP_W        = 2 * BYTE_W;
   localparam int unsigned CNT_W       = ADDR_W + 1;
   localparam int unsigned TIMEOUT_DEF = 50000;

   localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      HI,
      LO,
      CSUM,
      DONE,
      ERR
   } state_e;

   // States in which a frame is in progress.
   function automatic logic is_busy(input state_e s);
      return (s == LEN) || (s == HI) || (s == LO) || (s == CSUM);
   endfunction

   // Word count of a frame; a LEN byte of zero means a full 2**ADDR_W image.
   function automatic logic [CNT_W-1:0] frame_words(input logic [BYTE_W-1:0] len);
      if (len == '0) return CNT_W'(1 << ADDR_W);
      return CNT_W'(len);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in / imem write port out, plus the reload request.
// master drives the bytes; slave is the loader.
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic              rx_valid;
   logic [BYTE_W-1:0] rx_data;
   logic              load_req;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [OP_W-1:0]   wr_data;

   modport master (
      output rx_valid, rx_data, load_req,
      input  wr_en, wr_addr, wr_data
   );

   modport slave (
      input  rx_valid, rx_data, load_req,
      output wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/loader_timeout.sv
// Saturating idle counter: expired rises once TIMEOUT enabled cycles pass without clear.
module loader_timeout #(
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CW'(TIMEOUT))) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         expired <= 1'b0;
      end else begin
         count_q <= count_d;
         expired <= (count_d == CW'(TIMEOUT));
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Parses SYNC/LEN/payload/CSUM frames into imem writes and holds the CPU in reset
// until a checksum-valid image has been loaded.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int unsigned       TIMEOUT   = TIMEOUT_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   imem_loader_if.slave bus,
   output logic         cpu_rst_n,
   output logic         busy,
   output logic         done,
   output logic         err
);

   state_e            state_q, state_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [OP_W-1:0]   wr_data_q, wr_data_d;
   logic [BYTE_W-1:0] hi_q, hi_d;
   logic [BYTE_W-1:0] csum_q, csum_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  words_q, words_d;

   logic to_clear;
   logic to_enable;
   logic to_expired;

   assign to_enable = is_busy(state_q);
   assign to_clear  = bus.rx_valid | bus.load_req | ~is_busy(state_q);

   loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (to_clear),
      .enable  (to_enable),
      .expired (to_expired)
   );

   // Next state and datapath; reload beats incoming bytes, a byte beats the timeout.
   always_comb begin
      state_d   = state_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_en_q ? (wr_addr_q + ADDR_W'(1)) : wr_addr_q;
      wr_data_d = wr_data_q;
      hi_d      = hi_q;
      csum_d    = csum_q;
      cnt_d     = cnt_q;
      words_d   = words_q;

      if (bus.load_req) begin
         state_d   = IDLE;
         wr_addr_d = '0;
         csum_d    = '0;
         cnt_d     = '0;
         words_d   = '0;
      end else if (bus.rx_valid) begin
         case (state_q)
            IDLE: begin
               if (bus.rx_data == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
               words_d   = frame_words(bus.rx_data);
               csum_d    = bus.rx_data;
               wr_addr_d = '0;
               cnt_d     = '0;
               state_d   = HI;
            end
            HI: begin
               hi_d    = bus.rx_data;
               csum_d  = csum_q ^ bus.rx_data;
               state_d = LO;
            end
            LO: begin
               csum_d    = csum_q ^ bus.rx_data;
               wr_en_d   = 1'b1;
               wr_data_d = {hi_q, bus.rx_data};
               cnt_d     = cnt_q + CNT_W'(1);
               state_d   = ((cnt_q + CNT_W'(1)) == words_q) ? CSUM : HI;
            end
            CSUM: begin
               state_d = (bus.rx_data == csum_q) ? DONE : ERR;
            end
            DONE: begin
               state_d = DONE;
            end
            ERR: begin
               if (bus.rx_data == SYNC_BYTE) state_d = LEN;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else if (to_expired && is_busy(state_q)) begin
         state_d = ERR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         hi_q      <= '0;
         csum_q    <= '0;
         cnt_q     <= '0;
         words_q   <= '0;
         cpu_rst_n <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         hi_q      <= hi_d;
         csum_q    <= csum_d;
         cnt_q     <= cnt_d;
         words_q   <= words_d;
         cpu_rst_n <= (state_d == DONE);
         busy      <= is_busy(state_d);
         done      <= (state_d == DONE);
         err       <= (state_d == ERR);
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized frames for imem_loader; expected writes and status come from
// the frames the bench builds itself.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int unsigned TO = 40;

   logic clk = 1'b0;
   logic rst_n;
   logic cpu_rst_n, busy, done, err;

   imem_loader_if bus ();

   imem_loader #(
      .SYNC_BYTE (8'hA5),
      .TIMEOUT   (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [23:0] obs_q[$];
   logic [23:0] exp_q[$];
   logic [7:0]  pay[$];

   // Every imem write the DUT issues, as {addr, data}.
   always @(negedge clk) begin
      if (rst_n && bus.wr_en) obs_q.push_back({bus.wr_addr, bus.wr_data});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; one valid cycle then gap idle cycles.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic pulse_load;
      bus.load_req = 1'b1;
      @(negedge clk);
      bus.load_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] len, input logic bad, input int glo, input int ghi);
      logic [7:0] cs;
      int nw;
      nw = (len == 8'h00) ? 256 : int'(len);
      cs = len;
      for (int i = 0; i < 2 * nw; i++) cs = cs ^ pay[i];
      if (bad) cs = cs ^ 8'h01;
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < nw; i++) exp_q.push_back({8'(i), pay[2*i], pay[2*i+1]});
      send_byte(8'hA5, int'($urandom_range(ghi, glo)));
      send_byte(len, int'($urandom_range(ghi, glo)));
      for (int i = 0; i < 2 * nw; i++) send_byte(pay[i], int'($urandom_range(ghi, glo)));
      send_byte(cs, 0);
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_wr_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
   endtask

   task automatic check_status(input string tag, input logic exp_done);
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_cpu_rst_n"}, cpu_rst_n, exp_done);
      chk({tag, "_err"}, err, !exp_done);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic rand_payload(input int nbytes);
      pay.delete();
      for (int i = 0; i < nbytes; i++) pay.push_back(8'($urandom_range(255, 0)));
   endtask

   initial begin
      logic [7:0] len;
      logic bad;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.load_req = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wr_en", bus.wr_en, 1'b0);
      chk("rst_wr_addr", bus.wr_addr, 8'h00);
      chk("rst_wr_data", bus.wr_data, 16'h0000);
      chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Noise before sync, then the reference frame
      send_byte(8'h00, 1);
      send_byte(8'hFF, 1);
      chk("noise_busy", busy, 1'b0);
      pay = '{8'h12, 8'h34, 8'h56, 8'h78};
      send_frame(8'h02, 1'b0, 0, 2);
      check_status("frame_a", 1'b1);
      check_writes("frame_a");
      chk("frame_a_word0", exp_q[0], 24'h00_1234);
      chk("frame_a_word1", exp_q[1], 24'h01_5678);

      // Bytes in DONE are ignored
      send_byte(8'hA5, 2);
      chk("done_ignores_busy", busy, 1'b0);
      chk("done_ignores_done", done, 1'b1);

      // Reload drops the CPU back into reset on the next cycle
      bus.load_req = 1'b1;
      @(negedge clk);
      bus.load_req = 1'b0;
      chk("load_cpu_rst_n", cpu_rst_n, 1'b0);
      chk("load_done", done, 1'b0);

      // Reload wins over a coincident sync byte
      bus.load_req = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hA5;
      @(negedge clk);
      bus.load_req = 1'b0;
      bus.rx_valid = 1'b0;
      chk("load_vs_sync_busy", busy, 1'b0);
      send_byte(8'h02, 1);
      chk("load_vs_sync_busy2", busy, 1'b0);

      // Bad checksum: words still written, CPU held
      pay = '{8'h12, 8'h34, 8'h56, 8'h78};
      send_frame(8'h02, 1'b1, 0, 1);
      check_status("bad_csum", 1'b0);
      check_writes("bad_csum");

      // Random frames; the first starts straight from ERR
      for (int f = 0; f < 5; f++) begin
         if (f > 0) pulse_load();
         len = 8'($urandom_range(8, 1));
         bad = (f == 3);
         rand_payload(2 * int'(len));
         send_frame(len, bad, 0, 3);
         check_status($sformatf("rand%0d", f), !bad);
         check_writes($sformatf("rand%0d", f));
      end

      // Gap of exactly TO idle cycles between every byte is tolerated
      pulse_load();
      rand_payload(4);
      send_frame(8'h02, 1'b0, TO, TO);
      check_status("gap_edge", 1'b1);
      check_writes("gap_edge");

      // LEN=0 loads a full 256-word image
      pulse_load();
      rand_payload(512);
      send_frame(8'h00, 1'b0, 0, 0);
      check_status("len0", 1'b1);
      check_writes("len0");

      // Stall after the high byte: timeout, no write, then recover from ERR
      pulse_load();
      obs_q.delete();
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      send_byte(8'h11, TO + 1);
      chk("timeout_err", err, 1'b1);
      chk("timeout_busy", busy, 1'b0);
      send_byte(8'h22, 3);
      chk("timeout_no_write", obs_q.size(), 0);
      chk("timeout_cpu_rst_n", cpu_rst_n, 1'b0);
      rand_payload(6);
      send_frame(8'h03, 1'b0, 0, 2);
      check_status("after_timeout", 1'b1);
      check_writes("after_timeout");

      // Reset between the two bytes of a word
      pulse_load();
      obs_q.delete();
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      chk("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr_en", bus.wr_en, 1'b0);
      chk("mid_rst_wr_addr", bus.wr_addr, 8'h00);
      chk("mid_rst_wr_data", bus.wr_data, 16'h0000);
      chk("mid_rst_cpu_rst_n", cpu_rst_n, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_byte(8'h34, 3);
      chk("mid_rst_no_write", obs_q.size(), 0);
      chk("mid_rst_idle", busy, 1'b0);

      // Reload mid-word: the pending word is never written
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      pulse_load();
      send_byte(8'h34, 3);
      chk("mid_load_no_write", obs_q.size(), 0);
      chk("mid_load_busy", busy, 1'b0);
      chk("mid_load_done", done, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
